// File: rtl/rr_burst_arbiter_if.sv
// Shared output channel bundle for the round-robin burst arbiter.
// Requester lanes, the merged channel, and the grant status.
interface rr_burst_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]             req_last_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic                           out_valid_o;
  logic [DATA_W-1:0]              out_data_o;
  logic                           out_last_o;
  logic                           out_ready_i;
  logic [IDX_W-1:0]               gnt_idx_o;
  logic                           busy_o;

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  req_last_i,
    input  out_ready_i,
    output req_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_last_o,
    output gnt_idx_o,
    output busy_o
  );

  modport master (
    output req_valid_i,
    output req_data_i,
    output req_last_i,
    output out_ready_i,
    input  req_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_last_o,
    input  gnt_idx_o,
    input  busy_o
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among NUM_REQ
// requesters; a grant is held for the whole burst until the last beat.
module rr_burst_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
) (
  input logic               clk_i,
  input logic               arst_i,
  rr_burst_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  state_e state_q;
  state_e state_d;
  idx_t   ptr_q;
  idx_t   ptr_d;
  idx_t   own_q;
  idx_t   own_d;

  logic   locked;
  logic   scan_hit;
  idx_t   scan_idx;
  int     scan_j;
  idx_t   cand;
  idx_t   sel;
  logic   sel_vld;
  logic   sel_last;
  logic   grant_en;
  logic   hs;
  logic   hs_last;

  // Modulo increment that also wraps for non-power-of-2 counts.
  function automatic idx_t next_idx(input idx_t i);
    if (int'(i) == NUM_REQ - 1) begin
      return '0;
    end
    return i + idx_t'(1);
  endfunction

  assign locked = (state_q == S_LOCKED);

  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    scan_j   = 0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_j = int'(ptr_q) + k;
      if (scan_j >= NUM_REQ) begin
        scan_j = scan_j - NUM_REQ;
      end
      cand = idx_t'(scan_j);
      if (!scan_hit && bus.req_valid_i[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  always_comb begin
    sel      = scan_idx;
    sel_vld  = scan_hit;
    grant_en = scan_hit;
    if (locked) begin
      sel      = own_q;
      sel_vld  = bus.req_valid_i[own_q];
      grant_en = 1'b1;
    end
  end

  assign sel_last = bus.req_last_i[sel];
  assign hs       = sel_vld & bus.out_ready_i;
  assign hs_last  = hs & sel_last;

  always_comb begin
    bus.out_valid_o = sel_vld & ~arst_i;
    bus.out_data_o  = bus.req_data_i[sel];
    bus.out_last_o  = sel_last;
    bus.gnt_idx_o   = arst_i ? '0 : sel;
    bus.busy_o      = locked & ~arst_i;
    bus.req_ready_o = '0;
    if (grant_en && !arst_i) begin
      bus.req_ready_o[sel] = bus.out_ready_i;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          if (hs_last) begin
            ptr_d = next_idx(sel);
          end else begin
            state_d = S_LOCKED;
            own_d   = sel;
          end
        end
      end
      S_LOCKED: begin
        if (hs_last) begin
          state_d = S_IDLE;
          ptr_d   = next_idx(own_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Randomized bench for rr_burst_arbiter at NUM_REQ=4 and NUM_REQ=3,
// compared against a burst-level round-robin reference model.
module tb_rr_burst_arbiter;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic arst;

  always #5 clk = ~clk;

  rr_burst_arbiter_if #(.NUM_REQ(4), .DATA_W(DW)) if0 ();
  rr_burst_arbiter_if #(.NUM_REQ(3), .DATA_W(DW)) if1 ();

  rr_burst_arbiter #(.NUM_REQ(4), .DATA_W(DW)) u_dut0 (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (if0.slave)
  );

  rr_burst_arbiter #(.NUM_REQ(3), .DATA_W(DW)) u_dut1 (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (if1.slave)
  );

  int total = 0;
  int bad   = 0;

  int          nreq [2] = '{4, 3};
  bit          mlock [2];
  int          mptr  [2];
  int          mown  [2];
  bit          pend  [2][4];
  int          remb  [2][4];
  logic [DW-1:0] dat [2][4];
  bit          lst   [2][4];
  bit          ordy  [2];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if0.req_valid_i[i] = pend[0][i];
      if0.req_data_i[i]  = dat[0][i];
      if0.req_last_i[i]  = lst[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      if1.req_valid_i[i] = pend[1][i];
      if1.req_data_i[i]  = dat[1][i];
      if1.req_last_i[i]  = lst[1][i];
    end
    if0.out_ready_i = ordy[0];
    if1.out_ready_i = ordy[1];
  endtask

  task automatic get(input int d, output logic [3:0] rdy,
                     output logic ov, output logic [63:0] od,
                     output logic ol, output int gi, output logic bz);
    if (d == 0) begin
      rdy = if0.req_ready_o;
      ov  = if0.out_valid_o;
      od  = if0.out_data_o;
      ol  = if0.out_last_o;
      gi  = int'(if0.gnt_idx_o);
      bz  = if0.busy_o;
    end else begin
      rdy = {1'b0, if1.req_ready_o};
      ov  = if1.out_valid_o;
      od  = if1.out_data_o;
      ol  = if1.out_last_o;
      gi  = int'(if1.gnt_idx_o);
      bz  = if1.busy_o;
    end
  endtask

  // Reference: owner if locked, else first valid scanning from ptr.
  task automatic model_sel(input int d, output int sel, output bit ev,
                           output bit gen);
    int n;
    n   = nreq[d];
    sel = 0;
    ev  = 0;
    gen = 0;
    if (mlock[d]) begin
      sel = mown[d];
      ev  = pend[d][sel];
      gen = 1;
    end else begin
      for (int k = 0; k < n; k++) begin
        int j;
        j = (mptr[d] + k) % n;
        if (!ev && pend[d][j]) begin
          sel = j;
          ev  = 1;
          gen = 1;
        end
      end
    end
  endtask

  task automatic step(input int pst, input int prdy, input int maxlen);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < nreq[d]; i++) begin
        if (!pend[d][i]) begin
          dat[d][i] = {$urandom, $urandom};
          lst[d][i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 99) < pst) begin
            if (remb[d][i] == 0) remb[d][i] = $urandom_range(1, maxlen);
            pend[d][i] = 1;
            lst[d][i]  = (remb[d][i] == 1);
          end
        end
      end
      ordy[d] = ($urandom_range(0, 99) < prdy);
    end
    drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      int sel;
      bit ev;
      bit gen;
      bit hs;
      bit hl;
      logic [3:0] erdy;
      logic [3:0] rdy;
      logic ov;
      logic [63:0] od;
      logic ol;
      int gi;
      logic bz;
      model_sel(d, sel, ev, gen);
      erdy = '0;
      if (gen) erdy[sel] = ordy[d];
      get(d, rdy, ov, od, ol, gi, bz);
      chk($sformatf("d%0d_valid", d), 64'(ov), 64'(ev));
      chk($sformatf("d%0d_gnt", d), 64'(gi), 64'(sel));
      chk($sformatf("d%0d_ready", d), 64'(rdy), 64'(erdy));
      chk($sformatf("d%0d_busy", d), 64'(bz), 64'(mlock[d]));
      chk($sformatf("d%0d_data", d), od, dat[d][sel]);
      chk($sformatf("d%0d_last", d), 64'(ol), 64'(lst[d][sel]));
      hs = ev && ordy[d];
      hl = hs && lst[d][sel];
      if (hs) begin
        pend[d][sel] = 0;
        remb[d][sel] = hl ? 0 : remb[d][sel] - 1;
      end
      if (!mlock[d]) begin
        if (ev) begin
          if (hl) begin
            mptr[d] = (sel + 1) % nreq[d];
          end else begin
            mlock[d] = 1;
            mown[d]  = sel;
          end
        end
      end else if (hl) begin
        mlock[d] = 0;
        mptr[d]  = (mown[d] + 1) % nreq[d];
      end
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    arst = 1'b1;
    drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [3:0] rdy;
      logic ov;
      logic [63:0] od;
      logic ol;
      int gi;
      logic bz;
      get(d, rdy, ov, od, ol, gi, bz);
      chk($sformatf("d%0d_rst_ready", d), 64'(rdy), 64'd0);
      chk($sformatf("d%0d_rst_valid", d), 64'(ov), 64'd0);
      chk($sformatf("d%0d_rst_busy", d), 64'(bz), 64'd0);
      chk($sformatf("d%0d_rst_gnt", d), 64'(gi), 64'd0);
      mlock[d] = 0;
      mptr[d]  = 0;
      mown[d]  = 0;
      for (int i = 0; i < 4; i++) begin
        pend[d][i] = 0;
        remb[d][i] = 0;
      end
    end
    drive();
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ordy[d] = 1;
      for (int i = 0; i < 4; i++) begin
        pend[d][i] = (i < nreq[d]);
        remb[d][i] = 1;
        lst[d][i]  = 1;
        dat[d][i]  = {$urandom, $urandom};
      end
    end
    drive();
    rst_pulse();
    for (int c = 0; c < 12; c++) step(100, 100, 1);
    for (int c = 0; c < 500; c++) step(60, 70, 4);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) rst_pulse();
      step(35, 45, 5);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
